alu_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a single fixed-point ALU instance among N_REQ requesters. It accepts one operation at a time (instruction plus two Q6.10 operands), issues it to the ALU with a valid/busy handshake and waits for the ALU result. It then routes the result back to the winning requester, or returns an error on watchdog timeout. It sits between the requester blocks and the ALU: only this block drives the ALU input port.

---
 rtl/alu_rr_arbiter.sv | 149 ++++++++++++++
 tb/tb_alu_rr_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sequencer that shares one fixed-point ALU
// among N_REQ requesters. It handles one operation at a time: it grants a
// request, issues the operation to the ALU, and returns either the ALU
// result or a watchdog error to the winning requester.
module alu_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int INST_W  = 4,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ*INST_W-1:0]   i_inst,
    input  logic [N_REQ*DATA_W-1:0]   i_data_a,
    input  logic [N_REQ*DATA_W-1:0]   i_data_b,
    output logic [N_REQ-1:0]          o_gnt,
    output logic [N_REQ-1:0]          o_rsp_valid,
    output logic [DATA_W-1:0]         o_rsp_data,
    output logic                      o_rsp_err,
    output logic                      o_busy,
    output logic                      o_alu_valid,
    input  logic                      i_alu_busy,
    output logic [INST_W-1:0]         o_alu_inst,
    output logic [DATA_W-1:0]         o_alu_a,
    output logic [DATA_W-1:0]         o_alu_b,
    input  logic                      i_alu_out_valid,
    input  logic [DATA_W-1:0]         i_alu_data
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
    localparam logic [7:0]       TMO      = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   last_q;
    logic [IDX_W-1:0]   cur_q;
    logic [7:0]         wdog_q;
    logic [7:0]         wdog_d;
    logic [N_REQ-1:0]   gnt_q;
    logic [N_REQ-1:0]   rsp_valid_q;
    logic [DATA_W-1:0]  rsp_data_q;
    logic               rsp_err_q;
    logic               busy_q;
    logic               alu_valid_q;
    logic [INST_W-1:0]  alu_inst_q;
    logic [DATA_W-1:0]  alu_a_q;
    logic [DATA_W-1:0]  alu_b_q;

    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;

    assign wdog_d = wdog_q + 8'd1;

    // Pick the first requester after the last served one, wrapping around.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((int'(last_q) + i) % N_REQ);
            if (!win_vld && i_req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Control FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            last_q      <= LAST_RST;
            cur_q       <= '0;
            wdog_q      <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            alu_valid_q <= 1'b0;
            alu_inst_q  <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
        end else begin
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            alu_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (win_vld) begin
                        cur_q          <= win_idx;
                        gnt_q[win_idx] <= 1'b1;
                        alu_inst_q     <= i_inst[win_idx*INST_W +: INST_W];
                        alu_a_q        <= i_data_a[win_idx*DATA_W +: DATA_W];
                        alu_b_q        <= i_data_b[win_idx*DATA_W +: DATA_W];
                        busy_q         <= 1'b1;
                        state_q        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!i_alu_busy) begin
                        alu_valid_q <= 1'b1;
                        wdog_q      <= '0;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    wdog_q <= wdog_d;
                    // A real result wins over a watchdog expiry in the same cycle.
                    if (i_alu_out_valid) begin
                        rsp_data_q         <= i_alu_data;
                        rsp_err_q          <= 1'b0;
                        rsp_valid_q[cur_q] <= 1'b1;
                        last_q             <= cur_q;
                        busy_q             <= 1'b0;
                        state_q            <= S_IDLE;
                    end else if (wdog_d == TMO) begin
                        rsp_data_q         <= '0;
                        rsp_err_q          <= 1'b1;
                        rsp_valid_q[cur_q] <= 1'b1;
                        last_q             <= cur_q;
                        busy_q             <= 1'b0;
                        state_q            <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_gnt       = gnt_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_busy      = busy_q;
    assign o_alu_valid = alu_valid_q;
    assign o_alu_inst  = alu_inst_q;
    assign o_alu_a     = alu_a_q;
    assign o_alu_b     = alu_b_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed, table-driven bench for alu_rr_arbiter with a
// small behavioural ALU answering the issued operations.
module tb_alu_rr_arbiter;

    localparam int N  = 4;
    localparam int IW = 4;
    localparam int DW = 16;
    localparam int TO = 15;

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b0;
    logic [N-1:0]    i_req = '0;
    logic [N*IW-1:0] i_inst = '0;
    logic [N*DW-1:0] i_data_a = '0;
    logic [N*DW-1:0] i_data_b = '0;
    logic [N-1:0]    o_gnt;
    logic [N-1:0]    o_rsp_valid;
    logic [DW-1:0]   o_rsp_data;
    logic            o_rsp_err;
    logic            o_busy;
    logic            o_alu_valid;
    logic            i_alu_busy = 1'b0;
    logic [IW-1:0]   o_alu_inst;
    logic [DW-1:0]   o_alu_a;
    logic [DW-1:0]   o_alu_b;
    logic            i_alu_out_valid = 1'b0;
    logic [DW-1:0]   i_alu_data = '0;

    int n_chk  = 0;
    int n_fail = 0;

    alu_rr_arbiter #(.N_REQ(N), .INST_W(IW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_req           (i_req),
        .i_inst          (i_inst),
        .i_data_a        (i_data_a),
        .i_data_b        (i_data_b),
        .o_gnt           (o_gnt),
        .o_rsp_valid     (o_rsp_valid),
        .o_rsp_data      (o_rsp_data),
        .o_rsp_err       (o_rsp_err),
        .o_busy          (o_busy),
        .o_alu_valid     (o_alu_valid),
        .i_alu_busy      (i_alu_busy),
        .o_alu_inst      (o_alu_inst),
        .o_alu_a         (o_alu_a),
        .o_alu_b         (o_alu_b),
        .i_alu_out_valid (i_alu_out_valid),
        .i_alu_data      (i_alu_data)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [N-1:0]  req;
        int            idx;
        logic [IW-1:0] inst;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            busy;
        int            dly;
        bit            hold;
        logic [DW-1:0] exp;
    } op_t;

    op_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] alu_model(input logic [IW-1:0] inst,
                                                 input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b);
        case (inst)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a ^ b;
            default: return '0;
        endcase
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Non-winning slices carry marker values so a wrong winner is visible.
    task automatic set_ops(input int idx, input logic [IW-1:0] inst,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
        for (int k = 0; k < N; k++) begin
            i_inst[k*IW +: IW]   = 4'hF;
            i_data_a[k*DW +: DW] = 16'hDEAD;
            i_data_b[k*DW +: DW] = 16'hBEEF;
        end
        i_inst[idx*IW +: IW]   = inst;
        i_data_a[idx*DW +: DW] = a;
        i_data_b[idx*DW +: DW] = b;
    endtask

    task automatic run_op(input op_t r);
        logic [N-1:0] g;
        g = 4'b0001 << r.idx;
        set_ops(r.idx, r.inst, r.a, r.b);
        i_req      = r.req;
        i_alu_busy = (r.busy > 0);
        tick();
        chk("gnt", o_gnt, g);
        chk("busy_after_gnt", o_busy, 1);
        chk("alu_inst", o_alu_inst, r.inst);
        chk("alu_a", o_alu_a, r.a);
        chk("alu_b", o_alu_b, r.b);
        if (!r.hold) i_req = '0;
        for (int c = 0; c < r.busy; c++) begin
            tick();
            chk("alu_valid_blocked", o_alu_valid, 0);
        end
        i_alu_busy = 1'b0;
        tick();
        chk("alu_valid", o_alu_valid, 1);
        chk("gnt_pulse", o_gnt, 0);
        for (int d = 1; d < r.dly; d++) begin
            tick();
            chk("alu_valid_once", o_alu_valid, 0);
            chk("rsp_early", o_rsp_valid, 0);
        end
        i_alu_out_valid = 1'b1;
        i_alu_data      = alu_model(o_alu_inst, o_alu_a, o_alu_b);
        tick();
        i_alu_out_valid = 1'b0;
        chk("rsp_valid", o_rsp_valid, g);
        chk("rsp_data", o_rsp_data, r.exp);
        chk("rsp_err", o_rsp_err, 0);
        chk("busy_after_rsp", o_busy, 0);
    endtask

    initial begin
        op_t r;
        // req, idx, inst, a, b, busy, dly, hold, expected result
        tbl[0] = '{4'b0100, 2, 4'h0, 16'h0400, 16'h0200, 0, 2, 1'b0, 16'h0600};
        tbl[1] = '{4'b1000, 3, 4'h1, 16'h0200, 16'h0400, 5, 1, 1'b0, 16'hFE00};
        tbl[2] = '{4'b1111, 0, 4'h0, 16'h0100, 16'h0100, 0, 1, 1'b1, 16'h0200};
        tbl[3] = '{4'b1111, 1, 4'h1, 16'h0000, 16'h0400, 0, 3, 1'b1, 16'hFC00};
        tbl[4] = '{4'b1111, 2, 4'h2, 16'h1234, 16'h00FF, 0, 1, 1'b1, 16'h12CB};
        tbl[5] = '{4'b1111, 3, 4'h0, 16'h0C00, 16'h0400, 0, 2, 1'b1, 16'h1000};
        tbl[6] = '{4'b1111, 0, 4'h1, 16'h0400, 16'h0400, 0, 1, 1'b0, 16'h0000};

        // Reset state
        tick();
        tick();
        chk("rst_gnt", o_gnt, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_rsp_data", o_rsp_data, 0);
        chk("rst_rsp_err", o_rsp_err, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_alu_valid", o_alu_valid, 0);
        chk("rst_alu_inst", o_alu_inst, 0);
        chk("rst_alu_a", o_alu_a, 0);
        chk("rst_alu_b", o_alu_b, 0);
        i_rst_n = 1'b1;
        tick();

        for (int t = 0; t < 7; t++) run_op(tbl[t]);

        // Watchdog expiry on requester 1, then a normal operation
        set_ops(1, 4'h0, 16'h0100, 16'h0100);
        i_req = 4'b0010;
        tick();
        chk("tmo_gnt", o_gnt, 4'b0010);
        i_req = '0;
        tick();
        chk("tmo_alu_valid", o_alu_valid, 1);
        for (int c = 1; c < TO; c++) begin
            tick();
            chk("tmo_early", o_rsp_valid, 0);
        end
        tick();
        chk("tmo_rsp_valid", o_rsp_valid, 4'b0010);
        chk("tmo_rsp_err", o_rsp_err, 1);
        chk("tmo_rsp_data", o_rsp_data, 0);
        chk("tmo_busy", o_busy, 0);
        r = '{4'b0100, 2, 4'h0, 16'h0400, 16'h0200, 0, 1, 1'b0, 16'h0600};
        run_op(r);

        // Result held while idle; stray ALU strobe in IDLE ignored
        tick();
        tick();
        chk("rsp_data_held", o_rsp_data, 16'h0600);
        i_alu_out_valid = 1'b1;
        i_alu_data      = 16'h1234;
        tick();
        chk("stray_rsp_valid", o_rsp_valid, 0);
        tick();
        i_alu_out_valid = 1'b0;
        chk("stray_rsp_valid2", o_rsp_valid, 0);
        chk("stray_rsp_data", o_rsp_data, 16'h0600);
        chk("stray_busy", o_busy, 0);

        // Asynchronous reset while waiting on the ALU
        set_ops(0, 4'h0, 16'h0300, 16'h0100);
        i_req = 4'b0001;
        tick();
        chk("rw_gnt", o_gnt, 4'b0001);
        i_req = '0;
        tick();
        chk("rw_alu_valid", o_alu_valid, 1);
        tick();
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("rw_busy", o_busy, 0);
        chk("rw_rsp_data", o_rsp_data, 0);
        chk("rw_rsp_err", o_rsp_err, 0);
        chk("rw_rsp_valid", o_rsp_valid, 0);
        chk("rw_gnt0", o_gnt, 0);
        chk("rw_alu_valid0", o_alu_valid, 0);
        chk("rw_alu_inst", o_alu_inst, 0);
        chk("rw_alu_a", o_alu_a, 0);
        chk("rw_alu_b", o_alu_b, 0);
        tick();
        i_rst_n = 1'b1;
        i_alu_out_valid = 1'b1;
        i_alu_data      = 16'h0400;
        tick();
        i_alu_out_valid = 1'b0;
        chk("late_rsp_valid", o_rsp_valid, 0);
        chk("late_busy", o_busy, 0);
        r = '{4'b1111, 0, 4'h0, 16'h0040, 16'h0020, 0, 1, 1'b0, 16'h0060};
        run_op(r);
        r = '{4'b1000, 3, 4'h1, 16'h0400, 16'h0100, 0, 2, 1'b0, 16'h0300};
        run_op(r);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
